writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage and architectural register file owner. Latches the instruction leaving MEM, commits its result to a 32-entry register file, and presents the committed instruction as `inst_wb_out` (feeding decode's `inst_wb_in`). Serves decode's two register read ports combinationally, with same-cycle write-through so decode never reads a stale value for the instruction currently in WB.

## Interface
Parameters (taken from `constants_pkg`, not overridden per instance):
- `ARCH_LEN`, 32, datapath width
- `REG_FILE_LEN`, 32, number of architectural registers; address width `$clog2(REG_FILE_LEN)`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `inst_mem_in`  in  `inst_decoded_t`  instruction leaving MEM
- `flush_in`  in  1  squash the instruction being captured this edge
- `rd_addr_1`, `rd_addr_2`  in  5  decode source register indices
- `rd_data_1`, `rd_data_2`  out  `ARCH_LEN`  read data
- `inst_wb_out`  out  `inst_decoded_t`  instruction currently in WB
- `retire_count`  out  32  number of retired valid instructions
- `wb_error`  out  1  sticky: write-enabled instruction reached WB without ready data

## Operation
- WB latch `wb_q` captures `inst_mem_in` every edge (no stall). If `flush_in`, it captures `valid=0` and all other fields as given.
- Commit condition `commit = wb_q.valid & wb_q.reg_write_enable & wb_q.reg_data_ready & (wb_q.dst_reg != 0)`.
- When `commit` is high, `regs[wb_q.dst_reg] <= wb_q.dst_reg_data` at the next edge.
- Stores and `dst_reg == 0` never write. `regs[0]` is constant 0.
- Read port n:
  - `rd_addr_n == 0` returns 0.
  - Else, if `commit & rd_addr_n == wb_q.dst_reg`, returns `wb_q.dst_reg_data` (write-through).
  - Else returns `regs[rd_addr_n]`.
  - Both ports are independent; both may hit the bypass at the same time.
- Error: if `wb_q.valid & wb_q.reg_write_enable & ~wb_q.reg_data_ready`, there is no write and `wb_error` sets. It clears only on `rst`.
- `retire_count` increments by 1 at each edge where `wb_q.valid`, and wraps from 0xFFFFFFFF to 0.
- `inst_wb_out = wb_q` directly (registered output).

## Timing
- Reset values:
  - `wb_q.valid=0` and all `wb_q` fields 0.
  - All `regs` 0.
  - `retire_count=0`, `wb_error=0`.
  - Read outputs show 0 for all addresses during reset.
- Latency:
  - Instruction on `inst_mem_in` at edge N appears on `inst_wb_out` in cycle N..N+1.
  - It is readable via write-through in that same cycle.
  - It is in `regs` from edge N+1.
- Back-to-back writes to the same register: the later one wins. The read port sees the WB-stage value, never the older array value.
- Reset asserted mid-cycle clears state immediately (async), including an uncommitted `wb_q`. No write occurs at the next edge.
- `flush_in` affects capture only; an instruction already in `wb_q` still commits.
- Read path is purely combinational: address to data within the same cycle, with no clock dependence.

## Structure
- `inst_decoded_t` stays in `instruction_pkg`. `ARCH_LEN` and `REG_FILE_LEN` stay in `constants_pkg`. No new package types.
- Sub-module `reg_file`:
  - contains the array, async reset, one write port, two read ports, x0 handling and write-through;
  - the stage instantiates it and owns `wb_q`, `retire_count` and `wb_error`.

## Test plan
- Reset, then read all 32 addresses on both ports: every `rd_data` is 0. `retire_count=0`, `wb_error=0`.
- Send a valid reg-reg instruction, `dst_reg=5`, data `0xDEADBEEF`, ready:
  - in its WB cycle, `rd_addr_1=5` returns `0xDEADBEEF` (bypass);
  - one cycle later it still returns `0xDEADBEEF` (array);
  - `retire_count=1`.
- Send consecutive writes to x7 (`0x1`, then `0x2`) while reading x7 every cycle: reads show 0, 0x1, 0x2 in order. Also send a write to x0 with `0xFFFF`: a read of x0 stays 0.
- Send a store, and also an instruction with `reg_data_ready=0` and `dst_reg=3`:
  - x3 is unchanged;
  - `wb_error` goes high and stays high;
  - `retire_count` still increments for both.
- Assert `flush_in` with a valid write to x9 on the input: no write to x9, `inst_wb_out.valid=0`, `retire_count` unchanged. Then assert `rst` mid-cycle while a write is in WB: all state returns to reset values and the array is all zeros.
- Force `retire_count` near wrap (0xFFFFFFFF, by preloading or a long run), then retire one instruction: the counter reads 0.

Source files
------------

// File: rtl/constants_pkg.sv
// Datapath and register file sizing for the core.
package constants_pkg;
  localparam int ARCH_LEN     = 32;
  localparam int REG_FILE_LEN = 32;
  localparam int REG_ADDR_W   = $clog2(REG_FILE_LEN);
endpackage

// File: rtl/instruction_pkg.sv
// Decoded instruction record carried down the pipeline.
package instruction_pkg;
  import constants_pkg::*;

  typedef struct packed {
    logic                  valid;
    logic [ARCH_LEN-1:0]   pc;
    logic [6:0]            opcode;
    logic                  is_store;
    logic                  reg_write_enable;
    logic                  reg_data_ready;
    logic [REG_ADDR_W-1:0] dst_reg;
    logic [ARCH_LEN-1:0]   dst_reg_data;
  } inst_decoded_t;
endpackage

// File: rtl/writeback_stage_if.sv
// Bundle between MEM/decode and the writeback stage: instruction in, read ports, status out.
interface writeback_stage_if;
  import constants_pkg::*;
  import instruction_pkg::*;

  inst_decoded_t         inst_mem_in;
  logic                  flush_in;
  logic [REG_ADDR_W-1:0] rd_addr_1;
  logic [REG_ADDR_W-1:0] rd_addr_2;
  logic [ARCH_LEN-1:0]   rd_data_1;
  logic [ARCH_LEN-1:0]   rd_data_2;
  inst_decoded_t         inst_wb_out;
  logic [31:0]           retire_count;
  logic                  wb_error;

  modport master (
    output inst_mem_in, flush_in, rd_addr_1, rd_addr_2,
    input  rd_data_1, rd_data_2, inst_wb_out, retire_count, wb_error
  );

  modport slave (
    input  inst_mem_in, flush_in, rd_addr_1, rd_addr_2,
    output rd_data_1, rd_data_2, inst_wb_out, retire_count, wb_error
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file: one write port, two combinational read ports with write-through.
module reg_file
  import constants_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [ARCH_LEN-1:0]   wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr_1,
  input  logic [REG_ADDR_W-1:0] rd_addr_2,
  output logic [ARCH_LEN-1:0]   rd_data_1,
  output logic [ARCH_LEN-1:0]   rd_data_2
);

  logic [ARCH_LEN-1:0] regs_view [REG_FILE_LEN];

  // Flops rather than RAM: the whole file must clear asynchronously.
  generate
    for (genvar gi = 0; gi < REG_FILE_LEN; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_view[gi] = '0;
      end else begin : g_store
        logic [ARCH_LEN-1:0] q_reg;
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            q_reg <= '0;
          end else if (wr_en && (wr_addr == REG_ADDR_W'(gi))) begin
            q_reg <= wr_data;
          end
        end
        assign regs_view[gi] = q_reg;
      end
    end
  endgenerate

  // The pending write is visible in the same cycle so decode never sees a stale value.
  assign rd_data_1 = (rd_addr_1 == '0)                   ? '0      :
                     (wr_en && (rd_addr_1 == wr_addr))   ? wr_data :
                                                           regs_view[rd_addr_1];
  assign rd_data_2 = (rd_addr_2 == '0)                   ? '0      :
                     (wr_en && (rd_addr_2 == wr_addr))   ? wr_data :
                                                           regs_view[rd_addr_2];

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: latches the instruction leaving MEM, commits it to the register file,
// and tracks retired instructions and missing-data errors.
module writeback_stage
  import constants_pkg::*;
  import instruction_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  writeback_stage_if.slave  wb
);

  inst_decoded_t wb_q_reg;
  logic [31:0]   retire_count_reg;
  logic          wb_error_reg;
  logic          commit;
  logic          data_missing;

  assign commit       = wb_q_reg.valid & wb_q_reg.reg_write_enable &
                        wb_q_reg.reg_data_ready & (wb_q_reg.dst_reg != '0);
  assign data_missing = wb_q_reg.valid & wb_q_reg.reg_write_enable & ~wb_q_reg.reg_data_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q_reg         <= '0;
      retire_count_reg <= '0;
      wb_error_reg     <= 1'b0;
    end else begin
      wb_q_reg <= wb.inst_mem_in;
      // A flush squashes only the incoming instruction; the one already here still commits.
      if (wb.flush_in) begin
        wb_q_reg.valid <= 1'b0;
      end
      if (wb_q_reg.valid) begin
        retire_count_reg <= retire_count_reg + 32'd1;
      end
      if (data_missing) begin
        wb_error_reg <= 1'b1;
      end
    end
  end

  reg_file u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (commit),
    .wr_addr   (wb_q_reg.dst_reg),
    .wr_data   (wb_q_reg.dst_reg_data),
    .rd_addr_1 (wb.rd_addr_1),
    .rd_addr_2 (wb.rd_addr_2),
    .rd_data_1 (wb.rd_data_1),
    .rd_data_2 (wb.rd_data_2)
  );

  assign wb.inst_wb_out  = wb_q_reg;
  assign wb.retire_count = retire_count_reg;
  assign wb.wb_error     = wb_error_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed table, hand-written corner cases,
// and randomized traffic against a register-array reference model.
module tb_writeback_stage;
  import constants_pkg::*;
  import instruction_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_stage_if bus ();

  writeback_stage dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus.slave)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: plain architectural state plus the instruction sitting in WB.
  logic [31:0]   m_regs [32];
  inst_decoded_t m_wb;
  logic [31:0]   m_cnt;
  logic          m_err;

  typedef struct {
    inst_decoded_t inst;
    logic          flush;
    logic [4:0]    ra1;
    logic [4:0]    ra2;
    logic [31:0]   e1;
    logic [31:0]   e2;
    logic [31:0]   ecnt;
    logic          eerr;
    logic          evalid;
  } vec_t;

  vec_t vecs [10];

  function automatic inst_decoded_t mk(input logic v, input logic we, input logic rdy,
                                       input logic st, input logic [4:0] dst,
                                       input logic [31:0] data);
    inst_decoded_t i;
    i                  = '0;
    i.valid            = v;
    i.pc               = {$urandom_range(0, 1023), 2'b00};
    i.opcode           = st ? 7'h23 : 7'h33;
    i.is_store         = st;
    i.reg_write_enable = we;
    i.reg_data_ready   = rdy;
    i.dst_reg          = dst;
    i.dst_reg_data     = data;
    return i;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic logic m_commits(input inst_decoded_t i);
    return i.valid && i.reg_write_enable && i.reg_data_ready && (i.dst_reg != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_commits(m_wb) && (m_wb.dst_reg == a)) return m_wb.dst_reg_data;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_wb  = '0;
    m_cnt = 32'h0;
    m_err = 1'b0;
  endtask

  // Drive one instruction, let it be captured, and advance the model to match.
  task automatic step(input inst_decoded_t inst, input logic flush);
    bus.inst_mem_in = inst;
    bus.flush_in    = flush;
    @(posedge clk);
    if (m_commits(m_wb)) m_regs[m_wb.dst_reg] = m_wb.dst_reg_data;
    if (m_wb.valid && m_wb.reg_write_enable && !m_wb.reg_data_ready) m_err = 1'b1;
    if (m_wb.valid) m_cnt = m_cnt + 32'd1;
    m_wb = inst;
    if (flush) m_wb.valid = 1'b0;
    #1;
    bus.inst_mem_in = '0;
    bus.flush_in    = 1'b0;
  endtask

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
    bus.rd_addr_1 = a1;
    bus.rd_addr_2 = a2;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      set_reads(5'(a), 5'(31 - a));
      chk({tag, "_rd1"}, bus.rd_data_1, 32'h0);
      chk({tag, "_rd2"}, bus.rd_data_2, 32'h0);
    end
  endtask

  initial begin
    inst_decoded_t bubble;
    inst_decoded_t ri;
    logic          rflush;
    logic [4:0]    a1, a2;

    bubble          = '0;
    rst             = 1'b1;
    bus.inst_mem_in = '0;
    bus.flush_in    = 1'b0;
    bus.rd_addr_1   = '0;
    bus.rd_addr_2   = '0;
    model_reset();

    // Expected values for the directed table, worked out by hand.
    vecs[0] = '{mk(1,1,1,0,5,32'hDEADBEEF), 0, 5, 0, 32'hDEADBEEF, 32'h0,        0, 0, 1};
    vecs[1] = '{bubble,                      0, 5, 7, 32'hDEADBEEF, 32'h0,        1, 0, 0};
    vecs[2] = '{mk(1,1,1,0,7,32'h1),         0, 7, 5, 32'h1,        32'hDEADBEEF, 1, 0, 1};
    vecs[3] = '{mk(1,1,1,0,7,32'h2),         0, 7, 7, 32'h2,        32'h2,        2, 0, 1};
    vecs[4] = '{mk(1,1,1,0,0,32'hFFFF),      0, 0, 7, 32'h0,        32'h2,        3, 0, 1};
    vecs[5] = '{mk(1,0,1,1,4,32'h1234),      0, 4, 7, 32'h0,        32'h2,        4, 0, 1};
    vecs[6] = '{mk(1,1,0,0,3,32'h55),        0, 3, 0, 32'h0,        32'h0,        5, 0, 1};
    vecs[7] = '{bubble,                      0, 3, 5, 32'h0,        32'hDEADBEEF, 6, 1, 0};
    vecs[8] = '{mk(1,1,1,0,9,32'h99),        1, 9, 9, 32'h0,        32'h0,        6, 1, 0};
    vecs[9] = '{bubble,                      0, 9, 7, 32'h0,        32'h2,        6, 1, 0};

    // Reads are zero while reset is held.
    repeat (2) @(posedge clk);
    #1;
    set_reads(5'd5, 5'd31);
    chk("in_reset_rd1", bus.rd_data_1, 32'h0);
    chk("in_reset_rd2", bus.rd_data_2, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_count", bus.retire_count, 32'h0);
    chk("reset_error", 32'(bus.wb_error), 32'h0);
    chk("reset_wb_valid", 32'(bus.inst_wb_out.valid), 32'h0);
    check_all_zero("reset_scan");

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].inst, vecs[i].flush);
      set_reads(vecs[i].ra1, vecs[i].ra2);
      $display("vec %0d: dst=%0d data=%h flush=%0b rd1[%0d]=%h rd2[%0d]=%h cnt=%0d err=%0b",
               i, vecs[i].inst.dst_reg, vecs[i].inst.dst_reg_data, vecs[i].flush,
               vecs[i].ra1, bus.rd_data_1, vecs[i].ra2, bus.rd_data_2,
               bus.retire_count, bus.wb_error);
      chk($sformatf("vec%0d_rd1", i), bus.rd_data_1, vecs[i].e1);
      chk($sformatf("vec%0d_rd2", i), bus.rd_data_2, vecs[i].e2);
      chk($sformatf("vec%0d_count", i), bus.retire_count, vecs[i].ecnt);
      chk($sformatf("vec%0d_error", i), 32'(bus.wb_error), 32'(vecs[i].eerr));
      chk($sformatf("vec%0d_wb_valid", i), 32'(bus.inst_wb_out.valid), 32'(vecs[i].evalid));
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      ri = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 15) != 0, 1'b0, 5'($urandom_range(0, 31)), $urandom);
      ri.is_store = ~ri.reg_write_enable;
      rflush = ($urandom_range(0, 7) == 0);
      step(ri, rflush);
      a1 = ($urandom_range(0, 1) == 1) ? ri.dst_reg : 5'($urandom_range(0, 31));
      a2 = 5'($urandom_range(0, 31));
      set_reads(a1, a2);
      $display("rnd %0d: v=%0b we=%0b rdy=%0b dst=%0d data=%h flush=%0b rd1[%0d]=%h rd2[%0d]=%h",
               n, ri.valid, ri.reg_write_enable, ri.reg_data_ready, ri.dst_reg,
               ri.dst_reg_data, rflush, a1, bus.rd_data_1, a2, bus.rd_data_2);
      chk("rnd_rd1", bus.rd_data_1, m_read(a1));
      chk("rnd_rd2", bus.rd_data_2, m_read(a2));
      chk("rnd_count", bus.retire_count, m_cnt);
      chk("rnd_error", 32'(bus.wb_error), 32'(m_err));
      chk("rnd_wb_valid", 32'(bus.inst_wb_out.valid), 32'(m_wb.valid));
      chk("rnd_wb_data", bus.inst_wb_out.dst_reg_data, m_wb.dst_reg_data);
    end

    // Counter wrap: preload all-ones, retire one instruction.
    step(bubble, 1'b0);
    @(negedge clk);
    force dut.retire_count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_reg;
    m_cnt = 32'hFFFF_FFFF;
    step(mk(1,1,1,0,12,32'hCAFE0012), 1'b0);
    chk("wrap_preload", bus.retire_count, 32'hFFFF_FFFF);
    step(bubble, 1'b0);
    $display("wrap: retire_count=%h", bus.retire_count);
    chk("wrap_zero", bus.retire_count, 32'h0);

    // Asynchronous reset in the middle of a cycle while a write sits in WB.
    step(mk(1,1,1,0,11,32'h0000ABCD), 1'b0);
    set_reads(5'd11, 5'd11);
    chk("pre_rst_bypass", bus.rd_data_1, 32'h0000ABCD);
    rst = 1'b1;
    #1;
    model_reset();
    $display("mid-cycle reset: rd1[11]=%h cnt=%0d err=%0b", bus.rd_data_1,
             bus.retire_count, bus.wb_error);
    chk("async_rst_rd1", bus.rd_data_1, 32'h0);
    chk("async_rst_count", bus.retire_count, 32'h0);
    chk("async_rst_error", 32'(bus.wb_error), 32'h0);
    chk("async_rst_wb_valid", 32'(bus.inst_wb_out.valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(bubble, 1'b0);
    set_reads(5'd11, 5'd7);
    chk("post_rst_x11", bus.rd_data_1, 32'h0);
    chk("post_rst_x7", bus.rd_data_2, 32'h0);
    check_all_zero("post_rst_scan");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
